// File: rtl/adder_3_slice_sequencer.sv
// adder_3_slice_sequencer: WIDTH-bit add by stepping one shared 3-bit adder slice, LSB first
module adder_3_slice_sequencer #(
  parameter int WIDTH = 12,
  parameter int APPROX_SLICES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [2:0]       sl_a,
  output logic [2:0]       sl_b,
  output logic             sl_cin,
  output logic             sl_approx,
  input  logic [3:0]       sl_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [CNT_W-1:0] op_count
);
  localparam int NSL = WIDTH / 3;
  localparam int IW = NSL > 1 ? $clog2(NSL) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r, res;
  logic carry, cout, take, last, run;
  assign run = state == RUN;
  assign last = idx == IW'(NSL - 1);
  // in_ready is held low during reset so every output reads zero while rst_n is low
  assign in_ready = rst_n && (state == IDLE || (state == DONE && out_ready));
  assign take = in_valid && in_ready;
  assign sl_a = run ? a_r[3*idx +: 3] : 3'b000;
  assign sl_b = run ? b_r[3*idx +: 3] : 3'b000;
  assign sl_cin = run && carry;
  assign sl_approx = run && int'(idx) < APPROX_SLICES;
  assign out_sum = res;
  assign out_cout = cout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      res <= '0;
      cout <= 1'b0;
      out_valid <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        RUN: begin
          res[3*idx +: 3] <= sl_sum[2:0];
          carry <= sl_sum[3];
          idx <= idx + 1'b1;
          if (last) begin
            state <= DONE;
            out_valid <= 1'b1;
            cout <= sl_sum[3];
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
          if (op_count != '1) op_count <= op_count + 1'b1;
        end
        default: ;
      endcase
      // a capture in DONE overrides the return to IDLE, giving back-to-back operation
      if (take) begin
        a_r <= in_a;
        b_r <= in_b;
        carry <= in_cin;
        idx <= '0;
        state <= RUN;
      end
    end
endmodule

// File: tb/tb_adder_3_slice_sequencer.sv
// tb_adder_3_slice_sequencer: random and directed checks against a transaction-level model
module tb_adder_3_slice_sequencer;
  localparam int W = 12;
  localparam int NSL = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_cin = 0, out_ready = 0;
  logic [W-1:0] in_a = 0, in_b = 0;
  logic [2:0] sl_a1, sl_b1, sl_a2, sl_b2;
  logic sl_cin1, sl_approx1, sl_cin2, sl_approx2;
  logic [3:0] sl_sum1, sl_sum2;
  logic in_ready1, out_valid1, out_cout1, in_ready2, out_valid2, out_cout2;
  logic [W-1:0] out_sum1, out_sum2;
  logic [15:0] cnt1;
  logic [1:0] cnt2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign sl_sum1 = {1'b0, sl_a1} + {1'b0, sl_b1} + {3'b000, sl_cin1};
  assign sl_sum2 = {1'b0, sl_a2} + {1'b0, sl_b2} + {3'b000, sl_cin2};
  adder_3_slice_sequencer #(.WIDTH(W), .APPROX_SLICES(1), .CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .sl_a(sl_a1), .sl_b(sl_b1), .sl_cin(sl_cin1), .sl_approx(sl_approx1),
    .sl_sum(sl_sum1), .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
    .out_cout(out_cout1), .op_count(cnt1));
  adder_3_slice_sequencer #(.WIDTH(W), .APPROX_SLICES(0), .CNT_W(2)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .sl_a(sl_a2), .sl_b(sl_b2), .sl_cin(sl_cin2), .sl_approx(sl_approx2),
    .sl_sum(sl_sum2), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_cout(out_cout2), .op_count(cnt2));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // model: k = slice in progress (-1 when no add is running), vld = result pending
  int k = -1, ecnt = 0;
  bit vld = 0, m_ir, m_run;
  logic [W-1:0] ma = 0, mb = 0, esum = 0;
  logic mcin = 0, ecout = 0;
  logic [W:0] m_s;
  function automatic bit m_ready();
    return (k < 0 && !vld) || (vld && out_ready);
  endfunction
  function automatic int cin_at(int j);
    int m = (1 << (3 * j)) - 1;
    return (int'(ma) & m) + (int'(mb) & m) + int'(mcin) >> (3 * j);
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k = -1;
      vld = 0;
      ecnt = 0;
    end else begin
      m_ir = m_ready();
      if (vld && out_ready) begin
        vld = 0;
        ecnt++;
      end
      if (k >= 0) begin
        k++;
        if (k == NSL) begin
          k = -1;
          vld = 1;
        end
      end
      if (in_valid && m_ir) begin
        ma = in_a;
        mb = in_b;
        mcin = in_cin;
        k = 0;
        m_s = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
        esum = m_s[W-1:0];
        ecout = m_s[W];
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      m_run = k >= 0;
      chk("in_ready", in_ready1, m_ready());
      chk("in_ready2", in_ready2, m_ready());
      chk("out_valid", out_valid1, vld);
      chk("out_valid2", out_valid2, vld);
      chk("op_count", cnt1, ecnt);
      chk("op_count2", cnt2, ecnt > 3 ? 3 : ecnt);
      chk("sl_a", sl_a1, m_run ? (int'(ma) >> (3 * k)) & 7 : 0);
      chk("sl_b", sl_b1, m_run ? (int'(mb) >> (3 * k)) & 7 : 0);
      chk("sl_cin", sl_cin1, m_run ? cin_at(k) : 0);
      chk("sl_approx", sl_approx1, m_run && k < 1);
      chk("sl_a2", sl_a2, sl_a1);
      chk("sl_approx2", sl_approx2, 0);
      if (vld) begin
        chk("out_sum", out_sum1, esum);
        chk("out_cout", out_cout1, ecout);
        chk("out_sum2", out_sum2, esum);
        chk("out_cout2", out_cout2, ecout);
      end
    end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    out_ready = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!out_valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid_timeout", n < 20, 1);
  endtask
  task automatic handshake();
    @(posedge clk);
    #2;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  // starts from IDLE: accept on the next edge, record slice inputs, then consume the result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output logic [3:0] cseq,
                        output logic [3:0] aseq);
    int lat = 0;
    in_a = a;
    in_b = b;
    in_cin = c;
    in_valid = 1;
    out_ready = 0;
    tick();
    in_valid = 0;
    cseq = 0;
    aseq = 0;
    while (!out_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat <= NSL) begin
        cseq[lat-1] = sl_cin2;
        aseq[lat-1] = sl_approx1;
      end
    end
    chk("latency", lat, NSL + 1);
    s = out_sum1;
    co = out_cout1;
    handshake();
  endtask

  logic [W-1:0] s, snap, ra, rb;
  logic co, rc, snapc;
  logic [3:0] cseq, aseq;
  int acc, dn, n;
  int lit[5] = '{1, 2, 3, 3, 3};
  initial begin
    #3;
    chk("reset_in_ready", in_ready1, 0);
    chk("reset_out_valid", out_valid1, 0);
    chk("reset_op_count", cnt1, 0);
    chk("reset_out_sum", out_sum1, 0);
    do_reset();
    chk("idle_in_ready", in_ready1, 1);
    run_op(12'hFFF, 12'h001, 1'b0, s, co, cseq, aseq);
    chk("t1_sum", s, 12'h000);
    chk("t1_cout", co, 1);
    chk("t1_cin_seq", cseq, 4'b1110);
    chk("t1_model_sum", esum, 12'h000);
    run_op(12'h123, 12'h456, 1'b1, s, co, cseq, aseq);
    chk("t2_sum", s, 12'h57A);
    chk("t2_cout", co, 0);
    chk("t2_approx_seq", aseq, 4'b0001);
    chk("t2_model_sum", esum, 12'h57A);
    in_a = 12'h800;
    in_b = 12'h800;
    in_cin = 1;
    in_valid = 1;
    tick();
    in_valid = 0;
    wait_valid();
    snap = out_sum1;
    snapc = out_cout1;
    chk("t4_sum", snap, 12'h001);
    chk("t4_cout", snapc, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      in_valid = 1;
      in_a = W'($urandom);
      @(negedge clk);
      chk("t4_hold_valid", out_valid1, 1);
      chk("t4_hold_sum", out_sum1, snap);
      chk("t4_hold_cout", out_cout1, snapc);
      chk("t4_in_ready", in_ready1, 0);
    end
    in_valid = 0;
    handshake();
    chk("t4_count", cnt1, 3);
    in_a = 12'h0AB;
    in_b = 12'h0CD;
    in_cin = 0;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("t5_out_valid", out_valid1, 0);
    chk("t5_out_sum", out_sum1, 0);
    chk("t5_out_cout", out_cout1, 0);
    chk("t5_op_count", cnt1, 0);
    chk("t5_in_ready", in_ready1, 0);
    chk("t5_sl", {sl_a1, sl_b1, sl_cin1, sl_approx1}, 0);
    tick();
    rst_n = 1;
    tick();
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom);
    run_op(ra, rb, rc, s, co, cseq, aseq);
    chk("t5_after_sum", {co, s}, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
    chk("t5_after_count", cnt1, 1);
    do_reset();
    acc = 0;
    dn = 0;
    n = 0;
    out_ready = 1;
    while (dn < 3 && n < 60) begin
      in_valid = acc < 3;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_cin = 1'($urandom);
      @(negedge clk);
      if (out_valid1 && acc < 3) chk("t3_b2b_ready", in_ready1, 1);
      if (in_valid && in_ready1) acc++;
      if (out_valid1) dn++;
      tick();
      n++;
    end
    in_valid = 0;
    out_ready = 0;
    chk("t3_timeout", n < 60, 1);
    chk("t3_count", cnt1, 3);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, s, co, cseq, aseq);
      chk("t6_sum", {co, s}, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      chk("t6_count2", cnt2, lit[i]);
    end
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_cin = 1'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
